fetch_prefetcher: RTL and testbench

- Upstream fill stage for the instruction FIFO (`queue`, WIDTH 32).
- Walks a program counter and issues single-outstanding word reads to instruction memory.
- Pushes each returned word into the FIFO through its `wr_en`/`data_in` port, gated by the FIFO `full` flag.
- Handles control-flow redirects: discards any in-flight response and restarts fetch at the new PC.

---
 rtl/fetch_prefetcher.sv | 171 +++++++++++++++++
 tb/tb_fetch_prefetcher.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetcher.sv
// fetch_prefetcher: fill stage for the instruction FIFO.
// Walks a program counter, keeps at most one word read in flight, and pushes
// each returned word into the FIFO. A redirect discards any response still
// owed by memory and restarts fetch at the new PC.

module fetch_prefetcher #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
  parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(32'd4)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  q_full,
  output logic                  q_wr_en,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_flush,
  output logic                  busy
);

  // IDLE: nothing in flight. REQ: request presented, waiting for grant.
  // WAIT: granted, waiting for data. DROP: granted read whose data is stale.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [ADDR_WIDTH-1:0]   pc_nxt_s;
  logic                    accept_s;

  // A response is accepted only in WAIT and only when no redirect makes it stale.
  assign accept_s = (state_r == WAIT) && mem_rvalid && !redirect_valid;

  assign mem_req  = (state_r == REQ);
  assign mem_addr = pc_r;
  assign q_wr_en  = accept_s;
  assign q_data   = accept_s ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign q_flush  = redirect_valid;
  assign busy     = (state_r != IDLE);

  // State and PC registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Next-state and next-PC selection; redirects always take priority for the PC.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      IDLE: begin
        // The FIFO has a single writer, so a free slot now is still free
        // when the one outstanding response returns.
        if (redirect_valid) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = IDLE;
        end else if (enable && !q_full) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        // Once presented, the request is held until grant or redirect;
        // enable going low does not withdraw it.
        if (redirect_valid) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = mem_gnt ? DROP : IDLE;
        end else if (mem_gnt) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = IDLE;
          if (redirect_valid) begin
            pc_nxt_s = redirect_pc;
          end else begin
            pc_nxt_s = pc_r + PC_STEP;
          end
        end else if (redirect_valid) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        // Wait out the stale response; further redirects just update the PC.
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (mem_rvalid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pc_nxt_s    = pc_r;
      end
    endcase
  end

  fetch_prefetcher_checker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_addr       (mem_addr),
    .q_wr_en        (q_wr_en),
    .busy           (busy)
  );

endmodule

// Protocol invariants of the prefetcher, observed at its ports.
module fetch_prefetcher_checker #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  redirect_valid,
  input logic                  mem_req,
  input logic                  mem_gnt,
  input logic [ADDR_WIDTH-1:0] mem_addr,
  input logic                  q_wr_en,
  input logic                  busy
);

  // A stale word must never reach the FIFO.
  a_no_write_on_redirect : assert property (
    @(posedge clk) disable iff (reset) !(q_wr_en && redirect_valid));

  // An ungranted, unredirected request stays up with the same address.
  a_req_stable : assert property (
    @(posedge clk) disable iff (reset)
      (mem_req && !mem_gnt && !redirect_valid) |=> (mem_req && $stable(mem_addr)));

  // Writes only happen while a transaction is in progress.
  a_write_when_busy : assert property (
    @(posedge clk) disable iff (reset) q_wr_en |-> busy);

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Directed bench for fetch_prefetcher: memory and FIFO handshakes are driven
// cycle by cycle; expected values are hand-derived constants.

module tb_fetch_prefetcher;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        q_full;
  logic        q_wr_en;
  logic [31:0] q_data;
  logic        q_flush;
  logic        busy;

  int n_checks;
  int n_fails;

  fetch_prefetcher dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .q_full         (q_full),
    .q_wr_en        (q_wr_en),
    .q_data         (q_data),
    .q_flush        (q_flush),
    .busy           (busy)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs of the new state are then settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the DUT presents a request.
  task automatic wait_req();
    for (int i = 0; i < 8 && !mem_req; i++) tick();
    check_eq("req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  // Grant immediately, return addr^A5A5_0000 one cycle later, expect the push.
  task automatic fetch_word(input logic [31:0] addr);
    logic [31:0] next_pc;
    next_pc = addr + 32'd4;
    wait_req();
    check_eq("req_addr", mem_addr, addr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check_eq("busy_wait", {31'd0, busy}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = addr ^ 32'hA5A5_0000;
    #1;
    check_eq("wr_en", {31'd0, q_wr_en}, 32'd1);
    check_eq("wr_data", q_data, addr ^ 32'hA5A5_0000);
    check_eq("flush_idle", {31'd0, q_flush}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    #1;
    check_eq("pc_next", mem_addr, next_pc);
  endtask

  initial begin
    n_checks       = 0;
    n_fails        = 0;
    reset          = 1'b1;
    enable         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'd0;
    q_full         = 1'b0;

    // Reset state.
    #12;
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_wr", {31'd0, q_wr_en}, 32'd0);
    check_eq("rst_data", q_data, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_pc", mem_addr, 32'd0);

    // Streaming fetch of three words.
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    fetch_word(32'd0);
    fetch_word(32'd4);
    fetch_word(32'd8);
    check_eq("pc_12", mem_addr, 32'd12);

    // FIFO full holds off requests.
    q_full = 1'b1;
    tick();
    check_eq("full_req0", {31'd0, mem_req}, 32'd0);
    tick();
    check_eq("full_req1", {31'd0, mem_req}, 32'd0);
    check_eq("full_busy", {31'd0, busy}, 32'd0);
    q_full = 1'b0;
    tick();
    check_eq("unfull_req", {31'd0, mem_req}, 32'd1);
    check_eq("unfull_addr", mem_addr, 32'd12);
    fetch_word(32'd12);

    // Redirect during WAIT; stale response arrives two cycles later.
    tick();
    check_eq("s3_addr", mem_addr, 32'd16);
    mem_gnt = 1'b1;
    tick();
    mem_gnt        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check_eq("s3_flush", {31'd0, q_flush}, 32'd1);
    check_eq("s3_wr0", {31'd0, q_wr_en}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("s3_drop_busy", {31'd0, busy}, 32'd1);
    check_eq("s3_drop_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    #1;
    check_eq("s3_stale_wr", {31'd0, q_wr_en}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    check_eq("s3_idle", {31'd0, busy}, 32'd0);
    fetch_word(32'h0000_0100);

    // Redirect coinciding with the response in WAIT.
    tick();
    check_eq("s4_addr", mem_addr, 32'h0000_0104);
    mem_gnt = 1'b1;
    tick();
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b1;
    mem_rdata      = 32'h1234_5678;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check_eq("s4_wr", {31'd0, q_wr_en}, 32'd0);
    check_eq("s4_flush", {31'd0, q_flush}, 32'd1);
    tick();
    mem_rvalid     = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("s4_pc", mem_addr, 32'h0000_0200);
    tick();
    check_eq("s4_req", {31'd0, mem_req}, 32'd1);
    check_eq("s4_req_addr", mem_addr, 32'h0000_0200);

    // Redirect in REQ without grant withdraws the request; then PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("s5_req_drop", {31'd0, mem_req}, 32'd0);
    check_eq("s5_pc", mem_addr, 32'hFFFF_FFFC);
    fetch_word(32'hFFFF_FFFC);
    check_eq("s5_wrap", mem_addr, 32'd0);

    // Enable low in REQ keeps the request; reset in WAIT drops the response.
    fetch_word(32'd0);
    tick();
    check_eq("s6_req_addr", mem_addr, 32'd4);
    enable = 1'b0;
    tick();
    check_eq("s6_req_hold", {31'd0, mem_req}, 32'd1);
    check_eq("s6_addr_hold", mem_addr, 32'd4);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    check_eq("s6_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("s6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("s6_rst_pc", mem_addr, 32'd0);
    tick();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    #1;
    check_eq("s6_late_wr", {31'd0, q_wr_en}, 32'd0);
    check_eq("s6_late_data", q_data, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b1;
    #1;
    check_eq("s6_idle", {31'd0, busy}, 32'd0);
    check_eq("s6_pc", mem_addr, 32'd0);
    tick();
    mem_gnt = 1'b0;
    #1;
    check_eq("s6_gnt_ignored", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
